// File: rtl/bcd_result_formatter.sv
// rtl/bcd_result_formatter.sv - iterative binary-to-BCD result formatter with leading-zero blanking
//
// Converts an unsigned binary result into per-digit display codes using
// shift-add-3 (double dabble), one input bit per clock. It then blanks the
// leading zeros and registers the finished pattern onto digits.
// Codes: 0x0-0x9 digit, 0xA "E", 0xB "r", 0xF blank.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - conversion request, sampled only while idle
//   value  - unsigned binary result, sampled with start
//   err    - error indication, sampled with start; shows "Err"
//   busy   - high from the cycle after acceptance through the DONE cycle
//   done   - one-cycle pulse when digits has just been updated
//   digits - DIGITS 4-bit codes, [3:0] is the rightmost digit
module bcd_result_formatter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    input  logic                  err,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    // Idle display is a single "0". The error display is "Err" right-aligned.
    localparam logic [BW-1:0] RST_PAT = {{(DIGITS-1){4'hF}}, 4'h0};
    localparam logic [BW-1:0] ERR_PAT = {{(DIGITS-3){4'hF}}, 12'hABB};

    typedef enum logic [1:0] {IDLE, CONV, BLANK, DONE} state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     blank_pat;
    logic [BW-1:0]     staged;
    logic [CW-1:0]     cnt;
    logic              ovf;
    logic              lead;

    // Every nibble is corrected from its pre-adjust value before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Leading-zero suppression from the top digit down. Digit 0 is excluded
    // so that zero still shows a single "0".
    always_comb begin
        blank_pat = bcd;
        lead      = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (bcd[4*i +: 4] == 4'h0))
                blank_pat[4*i +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = err ? DONE : CONV;
            CONV:    if (cnt == CW'(1)) state_nx = BLANK;
            BLANK:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            bcd    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            staged <= RST_PAT;
            digits <= RST_PAT;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (err) begin
                            staged <= ERR_PAT;
                        end else begin
                            shreg <= value;
                            bcd   <= '0;
                            cnt   <= CW'(WIDTH);
                            ovf   <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    // A bit leaving the top nibble means the result needs more digits.
                    bcd   <= {bcd_adj[BW-2:0], shreg[WIDTH-1]};
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    ovf   <= ovf | bcd_adj[BW-1];
                    cnt   <= cnt - CW'(1);
                end
                BLANK: begin
                    if (ovf || (bcd[BW-1 -: 4] > 4'd9))
                        staged <= ERR_PAT;
                    else
                        staged <= blank_pat;
                end
                DONE: begin
                    digits <= staged;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_result_formatter.sv
// tb/tb_bcd_result_formatter.sv - directed self-checking bench for bcd_result_formatter
module tb_bcd_result_formatter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] value;
    logic        err;
    logic        busy;
    logic        done;
    logic [19:0] digits;

    int total = 0;
    int bad   = 0;
    int lat;
    int ndone;

    bcd_result_formatter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .value  (value),
        .err    (err),
        .busy   (busy),
        .done   (done),
        .digits (digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after the accepting edge. Returns the number of edges until done is seen.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Launches a numeric conversion and checks its latency, digits and the one-cycle done.
    task automatic run_num(input string tag, input logic [15:0] v, input logic [19:0] exp);
        int n;
        value = v;
        err   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        wait_done(n);
        chk({tag, "_lat"}, n, 18);
        chk({tag, "_digits"}, digits, exp);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        err   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_digits", digits, 20'hFFFF0);
        rst_n = 1'b1;
        @(negedge clk);

        run_num("zero", 16'd0, 20'hFFFF0);
        run_num("v12345", 16'd12345, 20'h12345);
        run_num("v65535", 16'd65535, 20'h65535);
        run_num("v907", 16'd907, 20'hFF907);

        // Error path: busy only in the DONE cycle, done one edge later.
        value = 16'd123;
        err   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        err   = 1'b0;
        chk("err_busy_hi", busy, 1'b1);
        chk("err_done_early", done, 1'b0);
        wait_done(lat);
        chk("err_lat", lat, 1);
        chk("err_busy_lo", busy, 1'b0);
        chk("err_digits", digits, 20'hFFABB);

        // Start and value changes while busy are ignored.
        repeat (2) @(negedge clk);
        value = 16'd42;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3 || k == 10) begin
                start = 1'b1;
                value = 16'd999;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (k == 18) chk("ign_digits", digits, 20'hFFF42);
        end
        start = 1'b0;
        chk("ign_ndone", ndone, 1);
        chk("ign_lat", lat, 18);

        // Reset in the middle of a conversion.
        value = 16'd12345;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_digits", digits, 20'hFFFF0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);
        chk("mid_rst_digits_hold", digits, 20'hFFFF0);

        // Back-to-back with start held high; new value presented in the done cycle.
        value = 16'd7;
        start = 1'b1;
        @(negedge clk);
        wait_done(lat);
        chk("b2b_lat1", lat, 18);
        chk("b2b_digits1", digits, 20'hFFFF7);
        value = 16'd99;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 60);
        start = 1'b0;
        chk("b2b_spacing", lat, 19);
        chk("b2b_digits2", digits, 20'hFFF99);
        @(negedge clk);
        chk("b2b_done_pulse", done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
